// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and entry packing for the PS/2 keyboard controller.
package kbd_pkg;

   localparam logic [7:0]  KBD_PFX_EXT    = 8'hE0;
   localparam logic [7:0]  KBD_PFX_BRK    = 8'hF0;
   localparam int unsigned KBD_ENTRY_W    = 10;
   localparam logic        KBD_REG_DATA   = 1'b0;
   localparam logic        KBD_REG_STATUS = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0
   } kbd_state_t;

   // FIFO entry layout: {brk, ext, code[7:0]}
   function automatic logic [KBD_ENTRY_W-1:0] kbd_entry(input logic       brk,
                                                        input logic       ext,
                                                        input logic [7:0] code);
      return {brk, ext, code};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises kclk/kdata, counts bits on kclk falls, checks
// start/stop (and parity when KBD_PARITY_CHECK_EN is defined), and abandons a frame
// that stalls mid-way for TIMEOUT_CYC cycles.
module ps2_frame_rx #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kclk,
   input  logic       kdata,
   output logic       byte_vld,
   output logic [7:0] rx_byte,
   output logic       ferr_p,
   output logic       perr_p
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic          kclk_s1_q, kclk_s2_q, kclk_prev_q;
   logic          kdata_s1_q, kdata_s2_q;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          byte_vld_q, byte_vld_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          fall;
   logic          parity_ok;

   assign fall = kclk_prev_q & ~kclk_s2_q;

`ifdef KBD_PARITY_CHECK_EN
   assign parity_ok = ^{shreg_q, par_q};
`else
   assign parity_ok = 1'b1;
`endif

   // Input synchronisers and edge-detect history; lines idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_s1_q   <= 1'b1;
         kclk_s2_q   <= 1'b1;
         kclk_prev_q <= 1'b1;
         kdata_s1_q  <= 1'b1;
         kdata_s2_q  <= 1'b1;
      end else begin
         kclk_s1_q   <= kclk;
         kclk_s2_q   <= kclk_s1_q;
         kclk_prev_q <= kclk_s2_q;
         kdata_s1_q  <= kdata;
         kdata_s2_q  <= kdata_s1_q;
      end
   end

   // Bit counter, shift register, watchdog and one-cycle result pulses.
   always_comb begin
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      idle_cnt_d = idle_cnt_q;
      byte_vld_d = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      if (fall) begin
         idle_cnt_d = '0;
         case (bit_idx_q)
            4'd0: begin
               // A high start bit is treated as noise; keep hunting.
               if (!kdata_s2_q) bit_idx_d = 4'd1;
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
               shreg_d   = {kdata_s2_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 4'd1;
            end
            4'd9: begin
               par_d     = kdata_s2_q;
               bit_idx_d = 4'd10;
            end
            default: begin
               bit_idx_d = 4'd0;
               if (!kdata_s2_q)     ferr_d     = 1'b1;
               else if (!parity_ok) perr_d     = 1'b1;
               else                 byte_vld_d = 1'b1;
            end
         endcase
      end else if (bit_idx_q != 4'd0) begin
         if (idle_cnt_q == TW'(TIMEOUT_CYC)) begin
            bit_idx_d  = 4'd0;
            idle_cnt_d = '0;
            ferr_d     = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
         end
      end
   end

   // Receiver state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx_q  <= 4'd0;
         shreg_q    <= 8'd0;
         par_q      <= 1'b0;
         idle_cnt_q <= '0;
         byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         idle_cnt_q <= idle_cnt_d;
         byte_vld_q <= byte_vld_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   assign byte_vld = byte_vld_q;
   assign rx_byte  = shreg_q;
   assign ferr_p   = ferr_q;
   assign perr_p   = perr_q;

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 keyboard controller: frame receiver, E0/F0 prefix decode FSM, event FIFO and
// CPU DATA/STATUS registers with a level IRQ.
// Optional feature macro: KBD_PARITY_CHECK_EN (enables odd-parity checking in ps2_frame_rx).
module kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        kclk,
   input  logic        kdata,
   input  logic        keyboard_cs,
   input  logic        rd_en,
   input  logic        addr,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic                   byte_vld;
   logic [7:0]             rx_byte;
   logic                   ferr_p, perr_p;

   kbd_state_t             state_q, state_d;
   logic                   push;
   logic [KBD_ENTRY_W-1:0] push_entry;

   logic [KBD_ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   empty, full, rd_req, pop, do_push, ovf_set, flag_clr;
   logic                   ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
   logic                   irq_q;

   ps2_frame_rx #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .kclk     (kclk),
      .kdata    (kdata),
      .byte_vld (byte_vld),
      .rx_byte  (rx_byte),
      .ferr_p   (ferr_p),
      .perr_p   (perr_p)
   );

   // Prefix decode: fold E0/F0 into the flags of the next non-prefix byte.
   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      push_entry = kbd_entry(state_q inside {S_F0, S_E0F0},
                             state_q inside {S_E0, S_E0F0}, rx_byte);
      if (byte_vld) begin
         if (rx_byte == KBD_PFX_EXT) begin
            state_d = S_E0;
         end else if (rx_byte == KBD_PFX_BRK) begin
            case (state_q)
               S_IDLE:  state_d = S_F0;
               S_E0:    state_d = S_E0F0;
               default: state_d = state_q;
            endcase
         end else begin
            push    = 1'b1;
            state_d = S_IDLE;
         end
      end
   end

   // Decode FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign rd_req   = keyboard_cs & rd_en;
   assign pop      = rd_req & (addr == KBD_REG_DATA) & ~empty;
   // A pop frees the slot being written, so a full FIFO still accepts a simultaneous push.
   assign do_push  = push & (~full | pop);
   assign ovf_set  = push & full & ~pop;
   assign flag_clr = rd_req & (addr == KBD_REG_STATUS);

   // FIFO pointer/count and sticky flag next-state; a set beats a same-cycle clear.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d  = ovf_set | (ovf_q  & ~flag_clr);
      ferr_d = ferr_p  | (ferr_q & ~flag_clr);
      perr_d = perr_p  | (perr_q & ~flag_clr);
   end

   // FIFO control, flags and IRQ registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         irq_q    <= (count_d != '0);
      end
   end

   // FIFO storage; contents are only observable through a non-empty head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_entry;
   end

   // CPU read mux; DATA reads as all-zero when the FIFO is empty.
   always_comb begin
      rdata = 32'd0;
      if (addr == KBD_REG_DATA) begin
         if (!empty) rdata = {21'd0, 1'b1, mem[rd_ptr_q]};
      end else begin
         rdata = {16'd0, 8'(count_q), 5'd0, perr_q, ferr_q, ovf_q};
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Self-checking bench for kbd_ctrl: drives PS/2 frames, scoreboards expected FIFO
// entries in a queue and compares them against CPU DATA reads.
module tb_kbd_ctrl;
   import kbd_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TO    = 300;
   localparam int unsigned HALF  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        kclk = 1'b1;
   logic        kdata = 1'b1;
   logic        keyboard_cs = 1'b0;
   logic        rd_en = 1'b0;
   logic        addr = 1'b0;
   logic [31:0] rdata;
   logic        irq;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [9:0]  sbq [$];

   always #5 clk = ~clk;

   kbd_ctrl #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .kclk        (kclk),
      .kdata       (kdata),
      .keyboard_cs (keyboard_cs),
      .rd_en       (rd_en),
      .addr        (addr),
      .rdata       (rdata),
      .irq         (irq)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_word(input int cnt, input logic perr,
                                               input logic ferr, input logic ovf);
      return {16'd0, 8'(cnt), 5'd0, perr, ferr, ovf};
   endfunction

   function automatic logic [9:0] entry(input logic brk, input logic ext, input logic [7:0] c);
      return {brk, ext, c};
   endfunction

   task automatic ps2_bit(input logic b);
      @(negedge clk) kdata = b;
      repeat (HALF) @(negedge clk);
      kclk = 1'b0;
      repeat (HALF) @(negedge clk);
      kclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                             input logic bad_stop = 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      @(negedge clk) kdata = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cpu_read(input logic a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      keyboard_cs = 1'b1;
      rd_en = 1'b1;
      #1 d = rdata;
      @(posedge clk);
      #1;
      keyboard_cs = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic expect_pop(input string tag);
      logic [31:0] d;
      cpu_read(KBD_REG_DATA, d);
      if (sbq.size() == 0) check(tag, d, 32'd0);
      else                 check(tag, d, {21'd0, 1'b1, sbq.pop_front()});
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      cpu_read(KBD_REG_STATUS, d);
      check(tag, d, exp);
   endtask

   initial begin
      logic [31:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'd0);
      addr = 1'b0;
      #1 check("rst_data", rdata, 32'd0);
      addr = 1'b1;
      #1 check("rst_status", rdata, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: single make code
      send_frame(8'h1C);
      sbq.push_back(entry(1'b0, 1'b0, 8'h1C));
      check("t1_irq_before", {31'd0, irq}, 32'd1);
      expect_pop("t1_data");
      check("t1_irq_after", {31'd0, irq}, 32'd0);

      // 2: prefix folding
      send_frame(8'hF0);
      send_frame(8'h1C);
      sbq.push_back(entry(1'b1, 1'b0, 8'h1C));
      check_status("t2_count1", status_word(1, 1'b0, 1'b0, 1'b0));
      expect_pop("t2_brk");
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h75);
      sbq.push_back(entry(1'b1, 1'b1, 8'h75));
      expect_pop("t2_ext_brk");
      send_frame(8'hE0);
      send_frame(8'h6B);
      sbq.push_back(entry(1'b0, 1'b1, 8'h6B));
      expect_pop("t2_ext");
      send_frame(8'hF0);
      send_frame(8'hE0);
      send_frame(8'h74);
      sbq.push_back(entry(1'b0, 1'b1, 8'h74));
      expect_pop("t2_e0_restart");

      // 3: overflow
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'h20 + 8'(i));
         if (i < DEPTH) sbq.push_back(entry(1'b0, 1'b0, 8'h20 + 8'(i)));
      end
      check("t3_irq", {31'd0, irq}, 32'd1);
      check_status("t3_ovf", status_word(DEPTH, 1'b0, 1'b0, 1'b1));
      check_status("t3_ovf_clr", status_word(DEPTH, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < DEPTH; i++) expect_pop("t3_drain");
      expect_pop("t3_empty");

      // 4: bad parity, then bad stop
      send_frame(8'h33, 1'b1, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
      check_status("t4_perr", status_word(0, 1'b1, 1'b0, 1'b0));
`else
      sbq.push_back(entry(1'b0, 1'b0, 8'h33));
      check_status("t4_noperr", status_word(1, 1'b0, 1'b0, 1'b0));
`endif
      expect_pop("t4_data");
      send_frame(8'h55, 1'b0, 1'b1);
      check_status("t4_ferr_stop", status_word(0, 1'b0, 1'b1, 1'b0));

      // 5: stalled frame times out, next frame is clean
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i));
      @(negedge clk) kdata = 1'b1;
      repeat (TO + 20) @(negedge clk);
      check_status("t5_ferr_to", status_word(0, 1'b0, 1'b1, 1'b0));
      send_frame(8'h29);
      sbq.push_back(entry(1'b0, 1'b0, 8'h29));
      expect_pop("t5_after_to");
      check_status("t5_clean", status_word(0, 1'b0, 1'b0, 1'b0));

      // 6: pop coincident with push while full
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'h40 + 8'(i));
         sbq.push_back(entry(1'b0, 1'b0, 8'h40 + 8'(i)));
      end
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(8'h5A >> i & 8'h01 ? 1'b1 : 1'b0);
      ps2_bit(~^8'h5A);
      @(negedge clk) kdata = 1'b1;
      repeat (HALF) @(negedge clk);
      kclk = 1'b0;
      // byte_vld is two edges after sync, so the push lands on the fourth edge.
      repeat (3) @(negedge clk);
      keyboard_cs = 1'b1;
      rd_en = 1'b1;
      addr = KBD_REG_DATA;
      #1 d = rdata;
      @(posedge clk);
      #1;
      keyboard_cs = 1'b0;
      rd_en = 1'b0;
      check("t6_pop_head", d, {21'd0, 1'b1, sbq.pop_front()});
      sbq.push_back(entry(1'b0, 1'b0, 8'h5A));
      repeat (HALF) @(negedge clk);
      kclk = 1'b1;
      repeat (HALF) @(negedge clk);
      check_status("t6_full_noovf", status_word(DEPTH, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < DEPTH; i++) expect_pop("t6_drain");
      expect_pop("t6_empty");

      // Reset mid-frame with a queued entry
      send_frame(8'h45);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      @(negedge clk) rst_n = 1'b0;
      addr = KBD_REG_DATA;
      #1 check("rstm_irq", {31'd0, irq}, 32'd0);
      check("rstm_data", rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      repeat (2) @(negedge clk);
      check_status("rstm_status", status_word(0, 1'b0, 1'b0, 1'b0));
      send_frame(8'h29);
      sbq.push_back(entry(1'b0, 1'b0, 8'h29));
      expect_pop("rstm_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
